// File: rtl/hex_token_parser.sv
// ASCII hex token parser: accumulates up to DIGITS hex characters per token and emits
// the value over valid/ready. Optional macro HEX_LOWERCASE_EN accepts 'a'-'f' as digits.
module hex_token_parser #(
    parameter  int DIGITS = 4,
    localparam int W      = 4 * DIGITS,
    localparam int NDW    = $clog2(DIGITS + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [7:0]     rx_data,
    input  logic           rx_valid,
    output logic           rx_ready,
    output logic [W-1:0]   val_data,
    output logic [NDW-1:0] val_ndigits,
    output logic           val_valid,
    input  logic           val_ready,
    output logic           err,
    output logic [1:0]     err_code
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2,
        SKIP  = 2'd3
    } state_t;

    localparam logic [NDW-1:0] CNT_ONE = NDW'(1);
    localparam logic [NDW-1:0] CNT_MAX = NDW'(DIGITS);
    localparam logic [1:0]     CODE_INVALID  = 2'b01;
    localparam logic [1:0]     CODE_OVERFLOW = 2'b10;

    // Returns {is_hex, nibble}
    function automatic logic [4:0] hex_decode(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        if ((c >= 8'h30) && (c <= 8'h39)) begin
            r = {1'b1, c[3:0]};
        end else if ((c >= 8'h41) && (c <= 8'h46)) begin
            r = {1'b1, c[3:0] + 4'd9};
`ifdef HEX_LOWERCASE_EN
        end else if ((c >= 8'h61) && (c <= 8'h66)) begin
            r = {1'b1, c[3:0] + 4'd9};
`endif
        end else begin
            r = 5'd0;
        end
        return r;
    endfunction

    function automatic logic is_delim(input logic [7:0] c);
        return (c == 8'h20) || (c == 8'h0D) || (c == 8'h0A) || (c == 8'h2C);
    endfunction

    state_t         state_r;
    logic [W-1:0]   acc_r;
    logic [NDW-1:0] cnt_r;
    logic           val_valid_r;
    logic [W-1:0]   val_data_r;
    logic [NDW-1:0] val_ndigits_r;
    logic           err_r;
    logic [1:0]     err_code_r;

    logic           rx_accept_s;
    logic           is_hex_s;
    logic           is_delim_s;
    logic [3:0]     digit_s;

    // Byte classification and acceptance qualification
    always_comb begin
        is_hex_s    = 1'b0;
        digit_s     = 4'd0;
        is_delim_s  = 1'b0;
        {is_hex_s, digit_s} = hex_decode(rx_data);
        is_delim_s  = is_delim(rx_data);
        rx_accept_s = rx_valid && rx_ready;
    end

    // The reset gate makes rx_ready low during the reset cycle itself
    assign rx_ready    = ~reset & (state_r != EMIT);
    assign val_data    = val_data_r;
    assign val_ndigits = val_ndigits_r;
    assign val_valid   = val_valid_r;
    assign err         = err_r;
    assign err_code    = err_code_r;

    // Token state machine with registered value and error outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            acc_r         <= '0;
            cnt_r         <= '0;
            val_valid_r   <= 1'b0;
            val_data_r    <= '0;
            val_ndigits_r <= '0;
            err_r         <= 1'b0;
            err_code_r    <= 2'b00;
        end else begin
            err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (rx_accept_s) begin
                        if (is_hex_s) begin
                            acc_r   <= {{(W-4){1'b0}}, digit_s};
                            cnt_r   <= CNT_ONE;
                            state_r <= ACCUM;
                        end else if (!is_delim_s) begin
                            err_r      <= 1'b1;
                            err_code_r <= CODE_INVALID;
                            state_r    <= SKIP;
                        end
                    end
                end
                ACCUM: begin
                    if (rx_accept_s) begin
                        if (is_hex_s) begin
                            if (cnt_r == CNT_MAX) begin
                                err_r      <= 1'b1;
                                err_code_r <= CODE_OVERFLOW;
                                acc_r      <= '0;
                                cnt_r      <= '0;
                                state_r    <= SKIP;
                            end else begin
                                acc_r <= {acc_r[W-5:0], digit_s};
                                cnt_r <= cnt_r + CNT_ONE;
                            end
                        end else if (is_delim_s) begin
                            val_data_r    <= acc_r;
                            val_ndigits_r <= cnt_r;
                            val_valid_r   <= 1'b1;
                            state_r       <= EMIT;
                        end else begin
                            err_r      <= 1'b1;
                            err_code_r <= CODE_INVALID;
                            acc_r      <= '0;
                            cnt_r      <= '0;
                            state_r    <= SKIP;
                        end
                    end
                end
                EMIT: begin
                    if (val_ready) begin
                        val_valid_r <= 1'b0;
                        acc_r       <= '0;
                        cnt_r       <= '0;
                        state_r     <= IDLE;
                    end
                end
                SKIP: begin
                    if (rx_accept_s && is_delim_s) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
